muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: 32-cycle shift-add multiply / restoring divide.
// Optional early completion for trivial operands is enabled by defining MULDIV_FAST_PATH_EN.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        in_flush,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    logic [2:0]  funct3_r;
    logic [31:0] opb_r, acc_hi_r, acc_lo_r;
    logic        res_neg_r;

    logic        accept_s, last_iter_s;
    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] sum_s, shl_s, diff_s;
    logic [31:0] iter_hi_s, iter_lo_s;
    logic [63:0] prod_s;
    logic [31:0] final_res_s;
`ifdef MULDIV_FAST_PATH_EN
    logic        div0_s, ovf_s, mzero_s, fast_hit_s;
    logic [31:0] fast_res_s;
`endif

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    // Operand decode: signedness, magnitudes and the sign the final result must carry
    always_comb begin
        a_signed_s = (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                     (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        b_signed_s = (in_funct3 == 3'd1) || (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        a_neg_s    = a_signed_s & in_rs1_data[31];
        b_neg_s    = b_signed_s & in_rs2_data[31];
        a_mag_s    = neg32(in_rs1_data, a_neg_s);
        b_mag_s    = neg32(in_rs2_data, b_neg_s);
        case (in_funct3)
            3'd0, 3'd1, 3'd2, 3'd3: neg_s = a_neg_s ^ b_neg_s;
            // a zero divisor must leave the all-ones quotient un-negated
            3'd4:                   neg_s = (a_neg_s ^ b_neg_s) & (in_rs2_data != 32'd0);
            3'd6:                   neg_s = a_neg_s;
            default:                neg_s = 1'b0;
        endcase
`ifdef MULDIV_FAST_PATH_EN
        div0_s     = in_funct3[2] & (in_rs2_data == 32'd0);
        ovf_s      = ((in_funct3 == 3'd4) || (in_funct3 == 3'd6)) &&
                     (in_rs1_data == 32'h8000_0000) && (in_rs2_data == 32'hFFFF_FFFF);
        mzero_s    = ~in_funct3[2] & ((in_rs1_data == 32'd0) || (in_rs2_data == 32'd0));
        fast_hit_s = div0_s | ovf_s | mzero_s;
        if (div0_s) begin
            fast_res_s = in_funct3[1] ? in_rs1_data : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            fast_res_s = in_funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            fast_res_s = 32'd0;
        end
`endif
    end

    // One datapath iteration plus the signed result formed from the final iteration
    always_comb begin
        sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : 33'd0);
        shl_s  = {acc_hi_r, acc_lo_r[31]};
        diff_s = shl_s - {1'b0, opb_r};
        if (!funct3_r[2]) begin
            iter_hi_s = sum_s[32:1];
            iter_lo_s = {sum_s[0], acc_lo_r[31:1]};
        end else if (!diff_s[32]) begin
            iter_hi_s = diff_s[31:0];
            iter_lo_s = {acc_lo_r[30:0], 1'b1};
        end else begin
            iter_hi_s = shl_s[31:0];
            iter_lo_s = {acc_lo_r[30:0], 1'b0};
        end
        prod_s = neg64({iter_hi_s, iter_lo_s}, res_neg_r);
        if (!funct3_r[2]) begin
            final_res_s = (funct3_r == 3'd0) ? prod_s[31:0] : prod_s[63:32];
        end else if (funct3_r[1]) begin
            final_res_s = neg32(iter_hi_s, res_neg_r);
        end else begin
            final_res_s = neg32(iter_lo_s, res_neg_r);
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = (state_r == IDLE) && in_valid && !in_flush;
        last_iter_s = (state_r == BUSY) && (cnt_r == 5'd31);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef MULDIV_FAST_PATH_EN
                    state_nxt_s = fast_hit_s ? DONE : BUSY;
`else
                    state_nxt_s = BUSY;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY:    state_nxt_s = last_iter_s ? DONE : BUSY;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
        if (in_flush) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            funct3_r  <= 3'd0;
            opb_r     <= 32'd0;
            acc_hi_r  <= 32'd0;
            acc_lo_r  <= 32'd0;
            res_neg_r <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= 32'd0;
        end else begin
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s != IDLE);
            out_valid <= (state_nxt_s == DONE);
            if (accept_s) begin
                cnt_r     <= 5'd0;
                funct3_r  <= in_funct3;
                opb_r     <= b_mag_s;
                acc_hi_r  <= 32'd0;
                acc_lo_r  <= a_mag_s;
                res_neg_r <= neg_s;
            end else if (state_r == BUSY && !in_flush) begin
                cnt_r    <= cnt_r + 5'd1;
                acc_hi_r <= iter_hi_s;
                acc_lo_r <= iter_lo_s;
            end else begin
                cnt_r    <= in_flush ? 5'd0 : cnt_r;
            end
            if (last_iter_s && !in_flush) begin
                out_res <= final_res_s;
`ifdef MULDIV_FAST_PATH_EN
            end else if (accept_s && fast_hit_s) begin
                out_res <= fast_res_s;
`endif
            end else begin
                out_res <= out_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; expected results hand-computed.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        in_flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_res;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ops    = 0;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_funct3   (in_funct3),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_flush    (in_flush),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_res     (out_res)
    );

    always #5 clk = ~clk;

    // Count every result strobe seen
    always @(negedge clk) begin
        if (out_valid) pulses <= pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; in_valid held for 'hold' extra cycles
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit fast, input int hold,
                          input string tag);
        int lat;
        int exp_lat;
        exp_lat     = (FAST && fast) ? 1 : 33;
        in_funct3   = f3;
        in_rs1_data = a;
        in_rs2_data = b;
        in_valid    = 1'b1;
        ops++;
        lat = 0;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k > hold) in_valid = 1'b0;
            if (k == 1) check_eq({tag, "_busy1"}, {31'd0, busy}, 32'd1);
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, out_res, exp);
        check_eq({tag, "_busydone"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq({tag, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
        check_eq({tag, "_hold"}, out_res, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_flush    = 1'b1;
        in_funct3   = 3'd0;
        in_rs1_data = 32'd9;
        in_rs2_data = 32'd9;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {30'd0, busy, out_valid}, 32'd0);
        check_eq("rst_res", out_res, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b0, 0, "mulhsu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, 0, "mulh_m1");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 0, "mulh_min");
        run_op(3'd0, 32'd0,          32'd5,          32'd0,         1'b1, 0, "mul_zero");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 0, "rem");
        run_op(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, 0, "divu0");
        run_op(3'd7, 32'd5,          32'd0,          32'd5,         1'b1, 0, "remu0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1'b1, 0, "div0_neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1'b1, 0, "rem0_neg");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 0, "rem_ovf");
        run_op(3'd5, 32'd100,        32'd7,          32'd14,        1'b0, 20, "divu_hold");
        run_op(3'd7, 32'd100,        32'd7,          32'd2,         1'b0, 0, "remu");

        // Flush during cycle 10 of a divide, then a multiply in cycle 11
        in_funct3   = 3'd4;
        in_rs1_data = 32'd1000;
        in_rs2_data = 32'd3;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        check_eq("flush_idle", {31'd0, busy}, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 0, "mul_after_flush");

        // Reset during cycle 5 of a multiply, then an op right at release
        in_funct3   = 3'd0;
        in_rs1_data = 32'd6;
        in_rs2_data = 32'd7;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_outs", {30'd0, busy, out_valid}, 32'd0);
        check_eq("midrst_res", out_res, 32'd0);
        rst_n = 1'b1;
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 0, "mul_after_rst");

        repeat (3) @(negedge clk);
        check_eq("pulses", pulses, ops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
